// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX/WB hazard-control bus.
//   slave  : hazard controller view (consumes pipeline status, drives control)
//   master : pipeline view (drives status, consumes control)
interface hazard_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned RW = 5;

  logic            id_valid_i;
  logic [RW-1:0]   id_rs1_i;
  logic [RW-1:0]   id_rs2_i;
  logic [RW-1:0]   id_rd_i;
  logic            id_uses_rs1_i;
  logic            id_uses_rs2_i;
  logic            id_writes_rd_i;
  logic            ex_busy_i;
  logic            br_taken_i;
  logic [XLEN-1:0] br_target_i;
  logic            wb_valid_i;
  logic [RW-1:0]   wb_rd_i;

  logic            pc_incr_en_o;
  logic            id_issue_o;
  logic            id_flush_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [1:0]      state_o;

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
    input  id_uses_rs1_i, id_uses_rs2_i, id_writes_rd_i,
    input  ex_busy_i, br_taken_i, br_target_i, wb_valid_i, wb_rd_i,
    output pc_incr_en_o, id_issue_o, id_flush_o, redirect_o, redirect_pc_o,
    output stall_cnt_o, flush_cnt_o, state_o
  );

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
    output id_uses_rs1_i, id_uses_rs2_i, id_writes_rd_i,
    output ex_busy_i, br_taken_i, br_target_i, wb_valid_i, wb_rd_i,
    input  pc_incr_en_o, id_issue_o, id_flush_o, redirect_o, redirect_pc_o,
    input  stall_cnt_o, flush_cnt_o, state_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: register scoreboard, issue/stall/flush control and perf counters.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; forces all control outputs low
//   bus    : hazard_ctrl_if.slave (ID operands, EX busy, branch redirect,
//            WB retire in; pc_incr/issue/flush/redirect/counters/state out)
module hazard_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_ctrl_if.slave   bus
);
  localparam int unsigned NREG = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NREG-1:0]  r_pend;
  logic [NREG-1:0]  w_pend_nxt;
  logic [NREG-1:0]  w_set;
  logic [NREG-1:0]  w_clr;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_hazard;
  logic             w_stall_cond;
  logic             w_issue;

  // Hazard looks only at the registered scoreboard; bit 0 is never set.
  assign w_hazard = bus.id_valid_i &
                    ((bus.id_uses_rs1_i  & r_pend[bus.id_rs1_i]) |
                     (bus.id_uses_rs2_i  & r_pend[bus.id_rs2_i]) |
                     (bus.id_writes_rd_i & r_pend[bus.id_rd_i]));

  assign w_stall_cond = bus.id_valid_i & (w_hazard | bus.ex_busy_i) & ~bus.br_taken_i;

  // Wrong-path instructions held in ID during FLUSH never issue.
  assign w_issue = bus.id_valid_i & ~w_hazard & ~bus.ex_busy_i & ~bus.br_taken_i &
                   (r_state != ST_FLUSH);

  // Clear applied before set so a same-cycle set/clear leaves the bit set.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_issue && bus.id_writes_rd_i && (bus.id_rd_i != 5'd0))
      w_set = NREG'(1) << bus.id_rd_i;
    if (bus.wb_valid_i)
      w_clr = NREG'(1) << bus.wb_rd_i;
    w_pend_nxt = ((r_pend & ~w_clr) | w_set) & ~NREG'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a taken branch overrides everything.
  always_comb begin
    w_state_nxt = ST_RUN;
    case (r_state)
      ST_RUN, ST_STALL: w_state_nxt = w_stall_cond ? ST_STALL : ST_RUN;
      ST_FLUSH:         w_state_nxt = ST_RUN;
      default:          w_state_nxt = ST_RUN;
    endcase
    if (bus.br_taken_i) w_state_nxt = ST_FLUSH;
  end

  // Scoreboard and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if ((r_state == ST_STALL) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bus.br_taken_i && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Combinational control outputs, held low while reset is asserted.
  always_comb begin
    bus.pc_incr_en_o  = 1'b0;
    bus.id_issue_o    = 1'b0;
    bus.id_flush_o    = 1'b0;
    bus.redirect_o    = 1'b0;
    bus.redirect_pc_o = '0;
    if (rst_n) begin
      bus.pc_incr_en_o  = bus.br_taken_i | ~(bus.id_valid_i & (w_hazard | bus.ex_busy_i));
      bus.id_issue_o    = w_issue;
      bus.id_flush_o    = bus.br_taken_i | ((r_state == ST_FLUSH) & bus.id_valid_i);
      bus.redirect_o    = bus.br_taken_i;
      bus.redirect_pc_o = bus.br_taken_i ? XLEN'(bus.br_target_i) : '0;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;
  assign bus.state_o     = r_state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic against a
// behavioural scoreboard/pipeline-control model.
module tb_hazard_ctrl;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int          CNT_MAX = 65535;
  localparam int          M_RUN   = 0;
  localparam int          M_STALL = 1;
  localparam int          M_FLUSH = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  bit   m_pend [32];
  int   m_mode;
  int   m_stall;
  int   m_flush;
  // Expected values for the current cycle.
  logic        e_issue, e_flush, e_pc_incr, e_redir, e_haz;
  logic [31:0] e_rpc;

  task automatic idle_inputs();
    bus.id_valid_i     = 1'b0;
    bus.id_rs1_i       = 5'd0;
    bus.id_rs2_i       = 5'd0;
    bus.id_rd_i        = 5'd0;
    bus.id_uses_rs1_i  = 1'b0;
    bus.id_uses_rs2_i  = 1'b0;
    bus.id_writes_rd_i = 1'b0;
    bus.ex_busy_i      = 1'b0;
    bus.br_taken_i     = 1'b0;
    bus.br_target_i    = 32'd0;
    bus.wb_valid_i     = 1'b0;
    bus.wb_rd_i        = 5'd0;
  endtask

  task automatic model_clear();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_mode  = M_RUN;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Evaluate expected combinational outputs from model state and current inputs.
  task automatic model_eval();
    bit r1, r2, rd;
    r1 = bus.id_uses_rs1_i  && bus.id_rs1_i != 0 && m_pend[bus.id_rs1_i];
    r2 = bus.id_uses_rs2_i  && bus.id_rs2_i != 0 && m_pend[bus.id_rs2_i];
    rd = bus.id_writes_rd_i && bus.id_rd_i  != 0 && m_pend[bus.id_rd_i];
    e_haz     = bus.id_valid_i && (r1 || r2 || rd);
    e_issue   = bus.id_valid_i && !e_haz && !bus.ex_busy_i && !bus.br_taken_i && m_mode != M_FLUSH;
    e_flush   = bus.br_taken_i || (m_mode == M_FLUSH && bus.id_valid_i);
    e_pc_incr = bus.br_taken_i || !(bus.id_valid_i && (e_haz || bus.ex_busy_i));
    e_redir   = bus.br_taken_i;
    e_rpc     = bus.br_taken_i ? bus.br_target_i : 32'd0;
  endtask

  // Apply the clock edge to the model.
  task automatic model_advance();
    bit stalled;
    stalled = bus.id_valid_i && (e_haz || bus.ex_busy_i);
    if (bus.wb_valid_i) m_pend[bus.wb_rd_i] = 1'b0;
    if (e_issue && bus.id_writes_rd_i && bus.id_rd_i != 0) m_pend[bus.id_rd_i] = 1'b1;
    if (m_mode == M_STALL && m_stall < CNT_MAX) m_stall++;
    if (bus.br_taken_i && m_flush < CNT_MAX) m_flush++;
    if (bus.br_taken_i)          m_mode = M_FLUSH;
    else if (m_mode == M_FLUSH)  m_mode = M_RUN;
    else                         m_mode = stalled ? M_STALL : M_RUN;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.id_valid_i  = 1'b1;
    bus.br_taken_i  = 1'b1;
    bus.br_target_i = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.pc_incr_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_pc_incr got=%0b exp=0", bus.pc_incr_en_o); end
    n_tests++; if (bus.id_issue_o !== 1'b0) begin n_fail++; $display("FAIL rst_issue got=%0b exp=0", bus.id_issue_o); end
    n_tests++; if (bus.id_flush_o !== 1'b0) begin n_fail++; $display("FAIL rst_flush got=%0b exp=0", bus.id_flush_o); end
    n_tests++; if (bus.redirect_o !== 1'b0) begin n_fail++; $display("FAIL rst_redirect got=%0b exp=0", bus.redirect_o); end
    n_tests++; if (bus.redirect_pc_o !== 32'd0) begin n_fail++; $display("FAIL rst_redirect_pc got=%h exp=0", bus.redirect_pc_o); end
    n_tests++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", bus.state_o); end
    n_tests++; if (bus.stall_cnt_o !== 16'd0 || bus.flush_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", bus.stall_cnt_o, bus.flush_cnt_o); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (bus.pc_incr_en_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_pc_incr got=%0b exp=1", bus.pc_incr_en_o); end
    @(posedge clk);
    #1;
    n_tests++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL post_rst_state got=%0d exp=0", bus.state_o); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    // A: writer of x5 issues.
    bus.id_valid_i = 1'b1; bus.id_writes_rd_i = 1'b1; bus.id_rd_i = 5'd5;
    settle();
    n_tests++; if (bus.id_issue_o !== 1'b1) begin n_fail++; $display("FAIL raw_writer_issue got=%0b exp=1", bus.id_issue_o); end
    advance();
    // B: reader of x5 blocked.
    bus.id_writes_rd_i = 1'b0; bus.id_uses_rs1_i = 1'b1; bus.id_rs1_i = 5'd5;
    settle();
    n_tests++; if (bus.id_issue_o !== 1'b0 || bus.pc_incr_en_o !== 1'b0) begin
      n_fail++; $display("FAIL raw_block got=issue%0b/pc%0b exp=0/0", bus.id_issue_o, bus.pc_incr_en_o); end
    advance();
    settle();
    n_tests++; if (bus.state_o !== 2'd1) begin n_fail++; $display("FAIL raw_state_stall got=%0d exp=1", bus.state_o); end
    advance();
    // D: WB of x5 this cycle does not release yet.
    bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd5;
    settle();
    n_tests++; if (bus.stall_cnt_o !== 16'd1) begin n_fail++; $display("FAIL raw_stall_cnt got=%0d exp=1", bus.stall_cnt_o); end
    n_tests++; if (bus.id_issue_o !== 1'b0) begin n_fail++; $display("FAIL raw_same_cycle_wb got=%0b exp=0", bus.id_issue_o); end
    advance();
    bus.wb_valid_i = 1'b0;
    settle();
    n_tests++; if (bus.id_issue_o !== 1'b1 || bus.state_o !== 2'd1 || bus.stall_cnt_o !== 16'd2) begin
      n_fail++; $display("FAIL raw_release got=issue%0b/st%0d/cnt%0d exp=1/1/2", bus.id_issue_o, bus.state_o, bus.stall_cnt_o); end
    advance();
    idle_inputs();
    settle();
    n_tests++; if (bus.state_o !== 2'd0 || bus.stall_cnt_o !== 16'd3) begin
      n_fail++; $display("FAIL raw_back_to_run got=st%0d/cnt%0d exp=0/3", bus.state_o, bus.stall_cnt_o); end
    advance();
  endtask

  task automatic test_x0();
    do_reset();
    bus.id_valid_i = 1'b1; bus.id_writes_rd_i = 1'b1; bus.id_rd_i = 5'd0;
    settle();
    n_tests++; if (bus.id_issue_o !== 1'b1) begin n_fail++; $display("FAIL x0_write_issue got=%0b exp=1", bus.id_issue_o); end
    advance();
    bus.id_uses_rs1_i = 1'b1; bus.id_rs1_i = 5'd0;
    settle();
    n_tests++; if (bus.id_issue_o !== 1'b1 || bus.pc_incr_en_o !== 1'b1) begin
      n_fail++; $display("FAIL x0_read_nostall got=issue%0b/pc%0b exp=1/1", bus.id_issue_o, bus.pc_incr_en_o); end
    advance();
    idle_inputs();
    settle();
    n_tests++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL x0_state got=%0d exp=0", bus.state_o); end
    advance();
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    bus.id_valid_i = 1'b1; bus.ex_busy_i = 1'b1;
    settle();
    advance();
    bus.br_taken_i = 1'b1; bus.br_target_i = 32'h0000_0100;
    settle();
    n_tests++; if (bus.state_o !== 2'd1) begin n_fail++; $display("FAIL br_pre_state got=%0d exp=1", bus.state_o); end
    n_tests++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h100) begin
      n_fail++; $display("FAIL br_redirect got=%0b/%h exp=1/00000100", bus.redirect_o, bus.redirect_pc_o); end
    n_tests++; if (bus.id_flush_o !== 1'b1 || bus.id_issue_o !== 1'b0 || bus.pc_incr_en_o !== 1'b1) begin
      n_fail++; $display("FAIL br_ctrl got=fl%0b/is%0b/pc%0b exp=1/0/1", bus.id_flush_o, bus.id_issue_o, bus.pc_incr_en_o); end
    advance();
    bus.br_taken_i = 1'b0; bus.br_target_i = 32'd0; bus.ex_busy_i = 1'b0;
    settle();
    n_tests++; if (bus.state_o !== 2'd2 || bus.id_flush_o !== 1'b1 || bus.id_issue_o !== 1'b0) begin
      n_fail++; $display("FAIL br_flush_cycle got=st%0d/fl%0b/is%0b exp=2/1/0", bus.state_o, bus.id_flush_o, bus.id_issue_o); end
    advance();
    idle_inputs();
    settle();
    n_tests++; if (bus.state_o !== 2'd0 || bus.flush_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL br_after got=st%0d/fcnt%0d exp=0/1", bus.state_o, bus.flush_cnt_o); end
    advance();
  endtask

  task automatic test_ex_busy();
    do_reset();
    bus.id_valid_i = 1'b1; bus.ex_busy_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_tests++; if (bus.pc_incr_en_o !== 1'b0 || bus.id_issue_o !== 1'b0) begin
        n_fail++; $display("FAIL busy_hold c=%0d got=pc%0b/is%0b exp=0/0", c, bus.pc_incr_en_o, bus.id_issue_o); end
      advance();
    end
    idle_inputs();
    settle();
    advance();
    settle();
    n_tests++; if (bus.stall_cnt_o !== 16'd3 || bus.state_o !== 2'd0) begin
      n_fail++; $display("FAIL busy_cnt got=cnt%0d/st%0d exp=3/0", bus.stall_cnt_o, bus.state_o); end
    advance();
  endtask

  task automatic test_set_wins();
    do_reset();
    bus.id_valid_i = 1'b1; bus.id_writes_rd_i = 1'b1; bus.id_rd_i = 5'd7;
    bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd7;
    settle();
    n_tests++; if (bus.id_issue_o !== 1'b1) begin n_fail++; $display("FAIL setwin_issue got=%0b exp=1", bus.id_issue_o); end
    advance();
    idle_inputs();
    bus.id_valid_i = 1'b1; bus.id_uses_rs2_i = 1'b1; bus.id_rs2_i = 5'd7;
    settle();
    n_tests++; if (bus.id_issue_o !== 1'b0) begin n_fail++; $display("FAIL setwin_pending got=%0b exp=0", bus.id_issue_o); end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bus.id_valid_i     = ($urandom_range(0, 3) != 0);
      bus.id_rs1_i       = 5'($urandom_range(0, 7));
      bus.id_rs2_i       = 5'($urandom_range(0, 7));
      bus.id_rd_i        = 5'($urandom_range(0, 7));
      bus.id_uses_rs1_i  = 1'($urandom_range(0, 1));
      bus.id_uses_rs2_i  = 1'($urandom_range(0, 1));
      bus.id_writes_rd_i = 1'($urandom_range(0, 1));
      bus.ex_busy_i      = ($urandom_range(0, 7) == 0);
      bus.br_taken_i     = ($urandom_range(0, 15) == 0);
      bus.br_target_i    = 32'($urandom);
      bus.wb_valid_i     = 1'($urandom_range(0, 1));
      bus.wb_rd_i        = 5'($urandom_range(0, 7));
      settle();
      n_tests++; if (bus.id_issue_o !== e_issue) begin n_fail++; $display("FAIL rand_issue c=%0d got=%0b exp=%0b", c, bus.id_issue_o, e_issue); end
      n_tests++; if (bus.id_flush_o !== e_flush) begin n_fail++; $display("FAIL rand_flush c=%0d got=%0b exp=%0b", c, bus.id_flush_o, e_flush); end
      n_tests++; if (bus.pc_incr_en_o !== e_pc_incr) begin n_fail++; $display("FAIL rand_pc_incr c=%0d got=%0b exp=%0b", c, bus.pc_incr_en_o, e_pc_incr); end
      n_tests++; if (bus.redirect_o !== e_redir || bus.redirect_pc_o !== e_rpc) begin
        n_fail++; $display("FAIL rand_redirect c=%0d got=%0b/%h exp=%0b/%h", c, bus.redirect_o, bus.redirect_pc_o, e_redir, e_rpc); end
      n_tests++; if (bus.state_o !== 2'(m_mode)) begin n_fail++; $display("FAIL rand_state c=%0d got=%0d exp=%0d", c, bus.state_o, m_mode); end
      n_tests++; if (bus.stall_cnt_o !== 16'(m_stall) || bus.flush_cnt_o !== 16'(m_flush)) begin
        n_fail++; $display("FAIL rand_counters c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.stall_cnt_o, bus.flush_cnt_o, m_stall, m_flush); end
      advance();
    end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    bus.id_valid_i = 1'b1; bus.ex_busy_i = 1'b1;
    for (int c = 0; c < 65540; c++) begin
      settle();
      advance();
    end
    n_tests++; if (bus.stall_cnt_o !== 16'hFFFF || m_stall != CNT_MAX) begin
      n_fail++; $display("FAIL sat_reach got=%h exp=ffff", bus.stall_cnt_o); end
    settle();
    advance();
    n_tests++; if (bus.stall_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", bus.stall_cnt_o); end
    // Mid-stall async reset with a branch pending on the inputs.
    bus.br_taken_i = 1'b1; bus.br_target_i = 32'h0000_0200;
    #1;
    n_tests++; if (bus.redirect_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_redirect got=%0b exp=1", bus.redirect_o); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.pc_incr_en_o !== 1'b0 || bus.id_issue_o !== 1'b0 || bus.id_flush_o !== 1'b0 ||
                   bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'd0) begin
      n_fail++; $display("FAIL midrst_outputs got=pc%0b/is%0b/fl%0b/rd%0b/%h exp=0/0/0/0/0", bus.pc_incr_en_o,
                         bus.id_issue_o, bus.id_flush_o, bus.redirect_o, bus.redirect_pc_o); end
    n_tests++; if (bus.state_o !== 2'd0 || bus.stall_cnt_o !== 16'd0 || bus.flush_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL midrst_state got=st%0d/%0d/%0d exp=0/0/0", bus.state_o, bus.stall_cnt_o, bus.flush_cnt_o); end
    do_reset();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    model_clear();
    test_reset();
    test_raw_stall();
    test_x0();
    test_branch_in_stall();
    test_ex_busy();
    test_set_wins();
    test_random();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32 (core::DATA_WIDTH): PC width.
REQ-002 SHALL have parameter CNT_W, default 16: width of performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 id_valid_i  input  1  ID holds a decoded instruction.
REQ-006 id_rs1_i, id_rs2_i, id_rd_i  input  5 each  ID register indices.
REQ-007 id_uses_rs1_i, id_uses_rs2_i, id_writes_rd_i  input  1 each  operand/destination usage flags.
REQ-008 ex_busy_i  input  1  EX is executing a multi-cycle op and cannot accept.
REQ-009 br_taken_i  input  1  EX resolved a taken branch/jump this cycle.
REQ-010 br_target_i  input  XLEN  redirect PC, valid with br_taken_i.
REQ-011 wb_valid_i, wb_rd_i  input  1, 5  WB retires a register write to wb_rd_i.
REQ-012 pc_incr_en_o  output  1  IF may advance PC (drives if_stage pc_incr_en_i).
REQ-013 id_issue_o  output  1  ID instruction moves to EX this cycle.
REQ-014 id_flush_o  output  1  ID contents squashed (bubble inserted into EX).
REQ-015 redirect_o, redirect_pc_o  output  1, XLEN  IF loads redirect_pc_o next edge.
REQ-016 stall_cnt_o, flush_cnt_o  output  CNT_W each  saturating stall-cycle / redirect counters.
REQ-017 state_o  output  2  current FSM state (RUN=0, STALL=1, FLUSH=2).

Function
REQ-018 SHALL keep a 32-bit pending scoreboard; bit n set = register n has an issued, unretired write.
REQ-019 hazard = id_valid_i & ((id_uses_rs1_i & pend[rs1]) | (id_uses_rs2_i & pend[rs2]) | (id_writes_rd_i & pend[rd])), using the registered scoreboard only.
REQ-020 Register x0 SHALL never be set pending and SHALL never cause a hazard.
REQ-021 id_issue_o = id_valid_i & ~hazard & ~ex_busy_i & ~br_taken_i & (state != FLUSH), combinational.
REQ-022 On issue with id_writes_rd_i and rd!=0, pend[rd] SHALL set at the next edge.
REQ-023 On wb_valid_i, pend[wb_rd_i] SHALL clear at the next edge; same-cycle WB clear does not release a stall (release one cycle later).
REQ-024 Simultaneous set and clear of the same bit: set wins.
REQ-025 redirect_o = br_taken_i, redirect_pc_o = br_target_i when br_taken_i, else 0; combinational.
REQ-026 id_flush_o = br_taken_i | (state == FLUSH & id_valid_i).
REQ-027 pc_incr_en_o = ~rst_state & (br_taken_i | ~(id_valid_i & (hazard | ex_busy_i))); redirect overrides stall.
REQ-028 FSM RUN->STALL when id_valid_i & (hazard | ex_busy_i) & ~br_taken_i.
REQ-029 FSM STALL->RUN when the stall condition is false at the edge; STALL->FLUSH on br_taken_i.
REQ-030 FSM any state->FLUSH on br_taken_i; FLUSH lasts exactly one cycle then ->RUN (or ->FLUSH again if br_taken_i).
REQ-031 In FLUSH, ID contents SHALL be treated as wrong-path and never issued.
REQ-032 stall_cnt_o SHALL increment each cycle in STALL; flush_cnt_o each cycle br_taken_i=1; both saturate at all-ones.
REQ-033 Stall-to-issue latency: instruction issues in the cycle after the edge where its last blocking WB is sampled.

Reset
REQ-034 While rst=0: scoreboard all zero, state RUN, counters 0, pc_incr_en_o=0, id_issue_o=0, id_flush_o=0, redirect_o=0, redirect_pc_o=0.
REQ-035 Reset assertion mid-stall or mid-flush SHALL abort immediately (asynchronous) with no partial scoreboard update.
REQ-036 First cycle after rst rises: state RUN, pc_incr_en_o=1 absent hazards.

Verification
REQ-037 Issue rd=5 writer, next ID uses rs1=5 -> id_issue_o=0, state STALL, stall_cnt increments per cycle; WB rd=5 -> issue one cycle after WB edge.
REQ-038 ID writes rd=0 then ID reads rs1=0 -> no stall, pend stays 0.
REQ-039 br_taken_i=1, br_target_i=0x0000_0100 while stalled -> redirect_o=1, redirect_pc_o=0x100, id_flush_o=1, next state FLUSH, then RUN; flush_cnt=1.
REQ-040 ex_busy_i high 3 cycles with valid ID -> pc_incr_en_o=0 and id_issue_o=0 for 3 cycles, stall_cnt=3.
REQ-041 Same-cycle issue of rd=7 and WB of rd=7 -> pend[7]=1 after edge.
REQ-042 Force stall_cnt to 0xFFFF, stall one cycle -> stays 0xFFFF; assert rst mid-stall -> all outputs 0 immediately.
